// File: rtl/button_pulse_repeat.sv
// Debounced push-button front end: emits one step pulse per accepted press,
// then auto-repeats while the button stays held.
module button_pulse_repeat #(
    parameter int STABLE_CYCLES = 4,
    parameter int REPEAT_DELAY  = 10,
    parameter int REPEAT_PERIOD = 5,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic       pulse,
    output logic       pressed,
    output logic [2:0] state_dbg
);

    localparam logic [2:0] WAIT_REL  = 3'd0;
    localparam logic [2:0] IDLE      = 3'd1;
    localparam logic [2:0] PRESS_CHK = 3'd2;
    localparam logic [2:0] HELD      = 3'd3;
    localparam logic [2:0] REL_CHK   = 3'd4;

    localparam int SCNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int RMAX   = REPEAT_DELAY + REPEAT_PERIOD;
    localparam int RCNT_W = $clog2(RMAX + 1);
    localparam bit REP_EN = (REPEAT_DELAY != 0);

    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STABLE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] R_FIRST   = RCNT_W'(REPEAT_DELAY);
    localparam logic [RCNT_W-1:0] R_WRAP    = RCNT_W'(RMAX);
    localparam logic              PIN_IDLE  = ACTIVE_LOW;

    logic              sync1, sync2, act;
    logic [2:0]        state, state_n;
    logic [SCNT_W-1:0] scnt, scnt_n;
    logic [RCNT_W-1:0] rcnt, rcnt_n, rcnt_inc, rcnt_step;
    logic              pulse_n, rep_hit;

    assign act       = sync2 ^ ACTIVE_LOW;
    assign state_dbg = state;

    // rcnt counts cycles since the press pulse; once past the first repeat it
    // folds back to REPEAT_DELAY at each period, so it never wraps or runs out.
    assign rcnt_inc  = rcnt + 1'b1;
    assign rep_hit   = REP_EN && ((rcnt_inc == R_FIRST) || (rcnt_inc == R_WRAP));
    assign rcnt_step = !REP_EN ? rcnt : ((rcnt_inc == R_WRAP) ? R_FIRST : rcnt_inc);

    always_comb begin
        state_n = state;
        scnt_n  = scnt;
        rcnt_n  = rcnt;
        pulse_n = 1'b0;
        case (state)
            WAIT_REL: begin
                if (act) begin
                    scnt_n = '0;
                end else if (scnt == SCNT_LAST) begin
                    state_n = IDLE;
                    scnt_n  = '0;
                end else begin
                    scnt_n = scnt + 1'b1;
                end
            end
            IDLE: begin
                if (act) begin
                    state_n = PRESS_CHK;
                    scnt_n  = '0;
                end
            end
            PRESS_CHK: begin
                if (!act) begin
                    state_n = IDLE;
                    scnt_n  = '0;
                end else if (scnt == SCNT_LAST) begin
                    state_n = HELD;
                    scnt_n  = '0;
                    rcnt_n  = '0;
                    pulse_n = 1'b1;
                end else begin
                    scnt_n = scnt + 1'b1;
                end
            end
            HELD: begin
                if (!act) begin
                    state_n = REL_CHK;
                    scnt_n  = '0;
                end else begin
                    rcnt_n  = rcnt_step;
                    // a repeat right after the press pulse is dropped so pulses stay isolated
                    pulse_n = rep_hit && !pulse;
                end
            end
            REL_CHK: begin
                if (act) begin
                    state_n = HELD;
                    rcnt_n  = rcnt_step;
                    pulse_n = rep_hit && !pulse;
                end else if (scnt == SCNT_LAST) begin
                    state_n = IDLE;
                    scnt_n  = '0;
                end else begin
                    scnt_n = scnt + 1'b1;
                end
            end
            default: begin
                state_n = WAIT_REL;
                scnt_n  = '0;
                rcnt_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= PIN_IDLE;
            sync2   <= PIN_IDLE;
            state   <= WAIT_REL;
            scnt    <= '0;
            rcnt    <= '0;
            pulse   <= 1'b0;
            pressed <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            state   <= state_n;
            scnt    <= scnt_n;
            rcnt    <= rcnt_n;
            pulse   <= pulse_n;
            pressed <= (state_n == HELD) || (state_n == REL_CHK);
        end
    end

endmodule
